user_obi_copy_dma: RTL and testbench

Word-granular memory copy/fill engine for the user domain: software configures it through a regbus subordinate port and it moves data as an OBI manager into the main crossbar (the user-domain manager port). It is the initiating end of the crossbar's manager interface, complementing the existing subordinate-side peripherals. One transaction outstanding at a time; completion raises a level interrupt into the core's external IRQ lines.

---
 rtl/croc_pkg.sv | 46 ++++
 rtl/user_dma_pkg.sv | 27 ++
 rtl/user_obi_copy_dma_regs.sv | 138 +++++++++++++
 rtl/user_obi_copy_dma.sv | 134 +++++++++++++
 tb/tb_user_obi_copy_dma.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/croc_pkg.sv
// Bus types shared across the croc SoC: regbus config port and the OBI manager port
// into the main crossbar (32-bit address/data, single-bit ID and optional fields).
package croc_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic [0:0]  a_optional;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        mgr_obi_a_chan_t a;
        logic            req;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic [0:0]  r_optional;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        mgr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } mgr_obi_rsp_t;

endpackage

// File: rtl/user_dma_pkg.sv
// Register map, CTRL/STATUS bit positions and FSM states of the user-domain copy DMA.
package user_dma_pkg;

    localparam logic [4:0] REG_SRC     = 5'h00;
    localparam logic [4:0] REG_DST     = 5'h04;
    localparam logic [4:0] REG_LEN     = 5'h08;
    localparam logic [4:0] REG_CTRL    = 5'h0C;
    localparam logic [4:0] REG_STATUS  = 5'h10;
    localparam logic [4:0] REG_PATTERN = 5'h14;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FILL   = 2;

    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_DONE = 1;
    localparam int unsigned STATUS_ERR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT
    } dma_state_e;

endpackage

// File: rtl/user_obi_copy_dma_regs.sv
// Regbus register file of the copy DMA: decode, storage, START pulse, sticky DONE/ERR.
// Fill mode (CTRL.FILL, PATTERN) exists only when USER_DMA_FILL_EN is defined.
module user_obi_copy_dma_regs
    import croc_pkg::*;
    import user_dma_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  reg_req_t    reg_req_i,
    output reg_rsp_t    reg_rsp_o,
    input  logic        busy_i,
    input  logic        done_set_i,
    input  logic        err_set_i,
    output logic        start_o,
    output logic [31:0] src_o,
    output logic [31:0] dst_o,
    output logic [31:0] len_o,
    output logic [31:0] pattern_o,
    output logic        fill_o,
    output logic        irq_o
);

    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] len_q, len_d;
    logic [31:0] pattern_q, pattern_d;
    logic        irq_en_q, irq_en_d;
    logic        fill_q, fill_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        wr;
    logic [4:0]  offset;
    logic        unused_req;

    assign offset     = reg_req_i.addr[4:0];
    assign wr         = reg_req_i.valid & reg_req_i.write;
    assign unused_req = ^{reg_req_i.addr[31:5], reg_req_i.wstrb};

    always_comb begin
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        pattern_d = pattern_q;
        irq_en_d  = irq_en_q;
        fill_d    = fill_q;
        done_d    = done_q;
        err_d     = err_q;
        start_o   = 1'b0;
        reg_rsp_o = '0;
        reg_rsp_o.ready = reg_req_i.valid;

        if (reg_req_i.valid) begin
            case (offset)
                REG_SRC: begin
                    reg_rsp_o.rdata = src_q;
                    if (wr && busy_i) reg_rsp_o.error = 1'b1;
                    else if (wr)      src_d = {reg_req_i.wdata[31:2], 2'b00};
                end
                REG_DST: begin
                    reg_rsp_o.rdata = dst_q;
                    if (wr && busy_i) reg_rsp_o.error = 1'b1;
                    else if (wr)      dst_d = {reg_req_i.wdata[31:2], 2'b00};
                end
                REG_LEN: begin
                    reg_rsp_o.rdata = len_q;
                    if (wr && busy_i) reg_rsp_o.error = 1'b1;
                    else if (wr)      len_d = reg_req_i.wdata;
                end
                REG_CTRL: begin
                    reg_rsp_o.rdata = {29'b0, fill_q, irq_en_q, 1'b0};
                    // A START while busy rejects the whole CTRL write, not only the pulse.
                    if (wr && busy_i && reg_req_i.wdata[CTRL_START]) begin
                        reg_rsp_o.error = 1'b1;
                    end else if (wr) begin
                        irq_en_d = reg_req_i.wdata[CTRL_IRQ_EN];
`ifdef USER_DMA_FILL_EN
                        fill_d   = reg_req_i.wdata[CTRL_FILL];
`endif
                        start_o  = reg_req_i.wdata[CTRL_START];
                    end
                end
                REG_STATUS: begin
                    reg_rsp_o.rdata = {29'b0, err_q, done_q, busy_i};
                    if (wr && reg_req_i.wdata[STATUS_DONE]) done_d = 1'b0;
                    if (wr && reg_req_i.wdata[STATUS_ERR])  err_d  = 1'b0;
                end
                REG_PATTERN: begin
`ifdef USER_DMA_FILL_EN
                    reg_rsp_o.rdata = pattern_q;
                    if (wr && busy_i) reg_rsp_o.error = 1'b1;
                    else if (wr)      pattern_d = reg_req_i.wdata;
`else
                    reg_rsp_o.error = 1'b1;
`endif
                end
                default: reg_rsp_o.error = 1'b1;
            endcase
        end

        if (start_o) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        // Hardware set wins over a coinciding software clear.
        if (done_set_i) done_d = 1'b1;
        if (err_set_i)  err_d  = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            pattern_q <= '0;
            irq_en_q  <= 1'b0;
            fill_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            pattern_q <= pattern_d;
            irq_en_q  <= irq_en_d;
            fill_q    <= fill_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign src_o     = src_q;
    assign dst_o     = dst_q;
    assign len_o     = len_q;
    assign pattern_o = pattern_q;
    assign fill_o    = fill_q;
    assign irq_o     = done_q & irq_en_q;

endmodule

// File: rtl/user_obi_copy_dma.sv
// Word copy/fill DMA: regbus-configured OBI manager, one transaction in flight at a time.
// Fill mode is compiled in only with USER_DMA_FILL_EN (see the register file).
module user_obi_copy_dma
    import croc_pkg::*;
    import user_dma_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  reg_req_t     reg_req_i,
    output reg_rsp_t     reg_rsp_o,
    output mgr_obi_req_t obi_req_o,
    input  mgr_obi_rsp_t obi_rsp_i,
    output logic         irq_o
);

    dma_state_e  state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        mode_fill_q, mode_fill_d;

    logic        start, busy, done_set, err_set;
    logic [31:0] cfg_src, cfg_dst, cfg_len, cfg_pattern;
    logic        cfg_fill;
    logic        unused_rsp;

    assign busy       = (state_q != ST_IDLE);
    assign unused_rsp = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

    user_obi_copy_dma_regs i_regs (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .reg_req_i  (reg_req_i),
        .reg_rsp_o  (reg_rsp_o),
        .busy_i     (busy),
        .done_set_i (done_set),
        .err_set_i  (err_set),
        .start_o    (start),
        .src_o      (cfg_src),
        .dst_o      (cfg_dst),
        .len_o      (cfg_len),
        .pattern_o  (cfg_pattern),
        .fill_o     (cfg_fill),
        .irq_o      (irq_o)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        mode_fill_d = mode_fill_q;
        done_set    = 1'b0;
        err_set     = 1'b0;
        obi_req_o   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start && cfg_len == 32'd0) begin
                    done_set = 1'b1;
                end else if (start) begin
                    src_d       = cfg_src;
                    dst_d       = cfg_dst;
                    cnt_d       = cfg_len;
                    mode_fill_d = cfg_fill;
                    data_d      = cfg_pattern;
                    state_d     = cfg_fill ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = src_q;
                if (obi_rsp_i.gnt) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (obi_rsp_i.rvalid && obi_rsp_i.r.err) begin
                    done_set = 1'b1;
                    err_set  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (obi_rsp_i.rvalid) begin
                    data_d  = obi_rsp_i.r.rdata;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                obi_req_o.req     = 1'b1;
                obi_req_o.a.we    = 1'b1;
                obi_req_o.a.be    = 4'hF;
                obi_req_o.a.addr  = dst_q;
                obi_req_o.a.wdata = data_q;
                if (obi_rsp_i.gnt) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (obi_rsp_i.rvalid && obi_rsp_i.r.err) begin
                    done_set = 1'b1;
                    err_set  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (obi_rsp_i.rvalid) begin
                    src_d = src_q + 32'd4;
                    dst_d = dst_q + 32'd4;
                    cnt_d = cnt_q - 32'd1;
                    if (cnt_q == 32'd1) begin
                        done_set = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = mode_fill_q ? ST_WR_REQ : ST_RD_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            mode_fill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            mode_fill_q <= mode_fill_d;
        end
    end

endmodule

// File: tb/tb_user_obi_copy_dma.sv
// Bench for user_obi_copy_dma: register table, directed copy/fill/error/reset sequences and
// random-stall copies checked against a word-level memory model.
module tb_user_obi_copy_dma;
    import croc_pkg::*;

`ifdef USER_DMA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08;
    localparam logic [31:0] A_CTRL = 32'h0C, A_STATUS = 32'h10, A_PATTERN = 32'h14;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    reg_req_t     reg_req;
    reg_rsp_t     reg_rsp;
    mgr_obi_req_t obi_req;
    mgr_obi_rsp_t obi_rsp;
    logic         irq;

    always #5 clk = ~clk;

    user_obi_copy_dma dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .reg_req_i (reg_req),
        .reg_rsp_o (reg_rsp),
        .obi_req_o (obi_req),
        .obi_rsp_i (obi_rsp),
        .irq_o     (irq)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [64:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        return {we, addr, we ? wdata : 32'h0};
    endfunction

    // ---------------- memory + OBI subordinate ----------------
    logic [31:0] mem [logic [31:0]];
    int   max_stall = 0, max_rlat = 0, err_read_idx = 0;
    int   rd_cnt = 0, wr_cnt = 0, req_cycles = 0;
    logic sb_en = 1'b1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    initial begin
        logic            out_pend, pend_err, tracking;
        int              pend_delay, stall_left;
        logic [31:0]     pend_data;
        mgr_obi_a_chan_t trk;
        logic [64:0]     t;
        out_pend = 1'b0; tracking = 1'b0; pend_err = 1'b0;
        pend_delay = 0; stall_left = 0; pend_data = '0; trk = '0;
        obi_rsp = '0;
        forever begin
            @(negedge clk);
            obi_rsp = '0;
            if (out_pend) begin
                if (pend_delay > 0) pend_delay--;
                else begin
                    obi_rsp.rvalid  = 1'b1;
                    obi_rsp.r.rdata = pend_data;
                    obi_rsp.r.err   = pend_err;
                    out_pend = 1'b0;
                end
            end else if (obi_req.req && !rst) begin
                req_cycles++;
                if (!tracking) begin
                    tracking   = 1'b1;
                    trk        = obi_req.a;
                    stall_left = $urandom_range(max_stall, 0);
                end else begin
                    check("req_stable", obi_req.a, trk);
                end
                if (stall_left > 0) stall_left--;
                else begin
                    obi_rsp.gnt = 1'b1;
                    tracking = 1'b0;
                    check("aid", obi_req.a.aid, 0);
                    check("a_optional", obi_req.a.a_optional, 0);
                    if (obi_req.a.we) begin
                        wr_cnt++;
                        check("be", obi_req.a.be, 4'hF);
                        mem[obi_req.a.addr] = obi_req.a.wdata;
                        pend_data = $urandom;
                        pend_err  = 1'b0;
                    end else begin
                        rd_cnt++;
                        pend_data = mem_rd(obi_req.a.addr);
                        pend_err  = (rd_cnt == err_read_idx);
                    end
                    t = txn(obi_req.a.we, obi_req.a.addr, obi_req.a.wdata);
                    if (sb_en && exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL txn_unexpected: got 0x%0h, expected no transaction", t);
                    end else if (sb_en) begin
                        check("txn", t, exp_q.pop_front());
                    end
                    out_pend   = 1'b1;
                    pend_delay = $urandom_range(max_rlat, 0);
                end
            end else begin
                tracking = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];
    int          exp_nwr;
    logic        exp_err;
    logic [31:0] job_dst;

    task automatic build_model(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                               input logic fill, input logic [31:0] pattern, input int err_idx);
        int rd;
        logic [31:0] data, a_s, a_d;
        ref_mem = mem;
        exp_q.delete();
        exp_nwr = 0;
        exp_err = 1'b0;
        rd = 0;
        for (int i = 0; i < int'(len); i++) begin
            a_s = src + 32'(4 * i);
            a_d = dst + 32'(4 * i);
            if (!fill) begin
                rd++;
                exp_q.push_back(txn(1'b0, a_s, 32'h0));
                if (rd == err_idx) begin
                    exp_err = 1'b1;
                    break;
                end
                data = ref_mem.exists(a_s) ? ref_mem[a_s] : 32'h0;
            end else begin
                data = pattern;
            end
            exp_q.push_back(txn(1'b1, a_d, data));
            ref_mem[a_d] = data;
            exp_nwr++;
        end
    endtask

    // ---------------- regbus driver ----------------
    task automatic reg_acc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output logic rdy);
        @(negedge clk);
        #1;
        reg_req.valid = 1'b1;
        reg_req.write = wr;
        reg_req.addr  = addr;
        reg_req.wdata = wdata;
        reg_req.wstrb = 4'hF;
        #1;
        rdata = reg_rsp.rdata;
        err   = reg_rsp.error;
        rdy   = reg_rsp.ready;
        @(posedge clk);
        #1;
        reg_req = '0;
    endtask

    task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata, output logic err);
        logic [31:0] rd;
        logic rdy;
        reg_acc(1'b1, addr, wdata, rd, err, rdy);
    endtask

    task automatic reg_rd(input logic [31:0] addr, output logic [31:0] rdata);
        logic err, rdy;
        reg_acc(1'b0, addr, 32'h0, rdata, err, rdy);
    endtask

    task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                             input logic fill, input logic irq_en, input logic [31:0] pattern,
                             input int err_idx);
        logic e;
        for (int i = 0; i < int'(len); i++)
            if (!mem.exists(src + 32'(4 * i))) mem[src + 32'(4 * i)] = $urandom;
        rd_cnt = 0;
        wr_cnt = 0;
        err_read_idx = err_idx;
        sb_en = 1'b1;
        job_dst = dst;
        build_model(src, dst, len, fill, pattern, err_idx);
        reg_wr(A_SRC, src, e);
        reg_wr(A_DST, dst, e);
        reg_wr(A_LEN, len, e);
        if (fill) reg_wr(A_PATTERN, pattern, e);
        reg_wr(A_CTRL, {29'b0, fill, irq_en, 1'b1}, e);
    endtask

    task automatic wait_done(input int budget, output logic [31:0] st);
        for (int i = 0; i < budget; i++) begin
            reg_rd(A_STATUS, st);
            if (st[1]) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL done_timeout: got STATUS 0x%0h after %0d polls, expected DONE=1", st, budget);
    endtask

    task automatic finish_job(input string name, input logic irq_en);
        logic [31:0] st, a;
        wait_done(400, st);
        check({name, "_status"}, st, {29'b0, exp_err, 1'b1, 1'b0});
        check({name, "_exp_q_empty"}, exp_q.size(), 0);
        for (int i = 0; i < exp_nwr; i++) begin
            a = job_dst + 32'(4 * i);
            check($sformatf("%s_mem%0d", name, i), mem_rd(a), ref_mem[a]);
        end
        check({name, "_irq"}, irq, irq_en);
    endtask

    // ---------------- register table ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } reg_vec_t;
    reg_vec_t vecs[$];

    function automatic void add_vec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, input logic err);
        reg_vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
        vecs.push_back(v);
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] rd, st, src, dst, len, pattern;
        logic        e, rdy, fill, irq_en, found;
        int          c, rc;

        add_vec(0, A_SRC, 0, 32'h0, 0);
        add_vec(0, A_STATUS, 0, 32'h0, 0);
        add_vec(1, A_SRC, 32'h1234_5677, 0, 0);
        add_vec(0, A_SRC, 0, 32'h1234_5674, 0);
        add_vec(1, A_DST, 32'hABCD_EF03, 0, 0);
        add_vec(0, A_DST, 0, 32'hABCD_EF00, 0);
        add_vec(1, A_LEN, 32'd7, 0, 0);
        add_vec(0, A_LEN, 0, 32'd7, 0);
        add_vec(1, A_CTRL, 32'h2, 0, 0);
        add_vec(0, A_CTRL, 0, 32'h2, 0);
        add_vec(1, A_CTRL, 32'h6, 0, 0);
        add_vec(0, A_CTRL, 0, FILL_EN ? 32'h6 : 32'h2, 0);
        add_vec(1, A_CTRL, 32'h0, 0, 0);
        add_vec(0, A_CTRL, 0, 32'h0, 0);
        add_vec(0, 32'h18, 0, 32'h0, 1);
        add_vec(1, 32'h1C, 32'h5, 0, 1);
        add_vec(1, A_PATTERN, 32'hDEAD_BEEF, 0, !FILL_EN);
        add_vec(0, A_PATTERN, 0, FILL_EN ? 32'hDEAD_BEEF : 32'h0, !FILL_EN);
        add_vec(1, A_STATUS, 32'h6, 0, 0);
        add_vec(0, A_STATUS, 0, 32'h0, 0);

        rst = 1'b1;
        reg_req = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_obi_req", obi_req, 0);
        check("reset_irq", irq, 0);
        check("reset_reg_ready", reg_rsp.ready, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            reg_acc(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e, rdy);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_error", i), e, vecs[i].err);
            check($sformatf("vec%0d_ready", i), rdy, 1);
        end

        // Directed copy, immediate grant: 4 cycles per word, DONE one cycle after last rvalid.
        max_stall = 0;
        max_rlat = 0;
        start_job(32'h1000_0000, 32'h1000_0100, 32'd4, 1'b0, 1'b1, 32'h0, 0);
        c = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            #2;
            if (k == 1) check("req_cycle_after_start", obi_req.req, 1);
            if (irq) begin
                c = k;
                break;
            end
        end
        check("done_latency", c, 17);
        check("basic_reads", rd_cnt, 4);
        check("basic_writes", wr_cnt, 4);
        finish_job("basic", 1'b1);

        // LEN=0: DONE and irq next cycle, no OBI traffic.
        rc = req_cycles;
        reg_wr(A_LEN, 32'd0, e);
        reg_wr(A_CTRL, 32'h3, e);
        @(negedge clk);
        #2;
        check("len0_irq", irq, 1);
        reg_rd(A_STATUS, st);
        check("len0_status", st, 32'h2);
        check("len0_no_req", req_cycles, rc);
        reg_wr(A_STATUS, 32'h2, e);
        @(negedge clk);
        #2;
        check("len0_irq_cleared", irq, 0);

        // Random stalls and response latencies, plus an address-wrap case.
        max_stall = 5;
        max_rlat = 2;
        for (int j = 0; j < 7; j++) begin
            src     = 32'h2000_0000 + 32'(4 * $urandom_range(63, 0));
            dst     = 32'h3000_0000 + 32'(4 * $urandom_range(63, 0));
            len     = 32'($urandom_range(6, 1));
            fill    = FILL_EN && ($urandom_range(1, 0) == 1);
            irq_en  = ($urandom_range(1, 0) == 1);
            pattern = $urandom;
            if (j == 6) begin
                src = 32'hFFFF_FFF8;
                dst = 32'h0000_0100;
                len = 32'd4;
                fill = 1'b0;
            end
            start_job(src, dst, len, fill, irq_en, pattern, 0);
            finish_job($sformatf("rand%0d", j), irq_en);
        end

        // Error response on the second read: one write, then abort.
        max_stall = 1;
        max_rlat = 1;
        start_job(32'h4000_0000, 32'h4000_1000, 32'd4, 1'b0, 1'b0, 32'h0, 2);
        finish_job("rd_err", 1'b0);
        check("rd_err_writes", wr_cnt, 1);
        check("rd_err_reads", rd_cnt, 2);

`ifdef USER_DMA_FILL_EN
        start_job(32'h0, 32'h5000_0000, 32'd3, 1'b1, 1'b0, 32'hDEAD_BEEF, 0);
        finish_job("fill", 1'b0);
        check("fill_reads", rd_cnt, 0);
        check("fill_writes", wr_cnt, 3);
`endif

        // Busy-write rejection, then asynchronous reset in the middle of a transfer.
        max_stall = 3;
        start_job(32'h6000_0000, 32'h6000_1000, 32'd8, 1'b0, 1'b1, 32'h0, 0);
        sb_en = 1'b0;
        reg_wr(A_LEN, 32'd5, e);
        check("busy_len_write_error", e, 1);
        reg_wr(A_SRC, 32'h7000_0000, e);
        check("busy_src_write_error", e, 1);
        reg_rd(A_LEN, rd);
        check("busy_len_unchanged", rd, 32'd8);
        reg_rd(A_STATUS, st);
        check("busy_status", st, 32'h1);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #2;
            if (obi_req.req) begin
                found = 1'b1;
                break;
            end
        end
        check("req_seen_before_reset", found, 1);
        rst = 1'b1;
        #1;
        check("reset_drops_req", obi_req.req, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rc = req_cycles;
        repeat (6) @(negedge clk);
        reg_rd(A_STATUS, st);
        check("post_reset_status", st, 32'h0);
        reg_rd(A_LEN, rd);
        check("post_reset_len", rd, 32'h0);
        check("post_reset_no_req", req_cycles, rc);
        check("post_reset_irq", irq, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
